// File: rtl/jt12_mix_sched.sv
// jt12_mix_sched: rate scheduler and shared-MAC arbiter for the FM/PSG
// interpolation mixer. Derives per-stage sample strobes for the FM (4 stages)
// and PSG (3 stages) upsampling chains from the master clock, queues one MAC
// job per strobe and hands a single multiply-accumulate unit to one job at a time.
//
// Ports
//   clk        master clock
//   rst_n      asynchronous reset, active low
//   fm_cen     per-stage FM strobes, bit k period FM_DIV>>k
//   psg_cen    per-stage PSG strobes, bit k period PSG_DIV>>k
//   mac_start  one-cycle pulse: MAC starts job mac_sel
//   mac_sel    job index: 0-3 FM stage 0-3, 4-6 PSG stage 0-2
//   mac_done   one-cycle pulse from MAC: current job finished
//   busy       high from mac_start until the job ends (done or abort)
//   overrun    sticky per-job flag: strobe hit an already pending job
//   timeout    sticky flag: a job was aborted after MAC_TMO cycles
//   clr        synchronous clear of overrun and timeout
module jt12_mix_sched #(
  parameter int unsigned FM_DIV  = 1008,
  parameter int unsigned PSG_DIV = 240,
  parameter int unsigned MAC_TMO = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] fm_cen,
  output logic [2:0] psg_cen,
  output logic       mac_start,
  output logic [2:0] mac_sel,
  input  logic       mac_done,
  output logic       busy,
  output logic [6:0] overrun,
  output logic       timeout,
  input  logic       clr
);

  localparam int unsigned NJOB   = 7;
  localparam int unsigned FM_CW  = $clog2(FM_DIV);
  localparam int unsigned PSG_CW = $clog2(PSG_DIV);
  localparam int unsigned TMO_W  = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  logic [FM_CW-1:0]  fm_cnt_q  [4];
  logic [FM_CW-1:0]  fm_cnt_d  [4];
  logic [PSG_CW-1:0] psg_cnt_q [3];
  logic [PSG_CW-1:0] psg_cnt_d [3];
  logic [3:0]        fm_cen_q,  fm_cen_d;
  logic [2:0]        psg_cen_q, psg_cen_d;

  state_t            state_q, state_d;
  logic [NJOB-1:0]   pend_q, pend_d;
  logic [NJOB-1:0]   ovr_q, ovr_d;
  logic [2:0]        sel_q, sel_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic              to_q, to_d;

  logic [NJOB-1:0]   req;
  logic [NJOB-1:0]   end_mask;
  logic              tmo_hit;
  logic [2:0]        pick;

  // Free-running per-stage dividers; strobe registered on the terminal count
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      fm_cen_d[k] = (fm_cnt_q[k] == FM_CW'((FM_DIV >> k) - 1));
      fm_cnt_d[k] = fm_cen_d[k] ? '0 : fm_cnt_q[k] + FM_CW'(1);
    end
    for (int k = 0; k < 3; k++) begin
      psg_cen_d[k] = (psg_cnt_q[k] == PSG_CW'((PSG_DIV >> k) - 1));
      psg_cnt_d[k] = psg_cen_d[k] ? '0 : psg_cnt_q[k] + PSG_CW'(1);
    end
  end

  // Fixed priority: lowest pending index wins
  always_comb begin
    pick = 3'd0;
    for (int i = int'(NJOB) - 1; i >= 0; i--) begin
      if (pend_q[i]) pick = 3'(i);
    end
  end

  // Arbiter FSM next state, job queue and sticky flags
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    tmo_d    = tmo_q;
    start_d  = 1'b0;
    busy_d   = 1'b0;
    tmo_hit  = 1'b0;
    end_mask = '0;
    req      = {psg_cen_q, fm_cen_q};

    case (state_q)
      S_IDLE: begin
        if (pend_q != '0) begin
          sel_d   = pick;
          state_d = S_START;
        end
      end
      S_START: begin
        start_d = 1'b1;
        busy_d  = 1'b1;
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        tmo_d   = tmo_q + TMO_W'(1);
        // done in the last allowed cycle still counts as a normal finish
        tmo_hit = (tmo_q == TMO_W'(MAC_TMO - 1)) && !mac_done;
        if (mac_done || tmo_hit) begin
          end_mask = NJOB'(1) << sel_q;
          state_d  = S_IDLE;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A strobe landing on the clearing cycle re-arms the job instead of overrunning
    pend_d = (pend_q & ~end_mask) | req;
    ovr_d  = (clr ? '0 : ovr_q) | (req & pend_q & ~end_mask);
    to_d   = (clr ? 1'b0 : to_q) | tmo_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) fm_cnt_q[k] <= '0;
      for (int k = 0; k < 3; k++) psg_cnt_q[k] <= '0;
      fm_cen_q  <= '0;
      psg_cen_q <= '0;
      state_q   <= S_IDLE;
      pend_q    <= '0;
      ovr_q     <= '0;
      sel_q     <= '0;
      tmo_q     <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) fm_cnt_q[k] <= fm_cnt_d[k];
      for (int k = 0; k < 3; k++) psg_cnt_q[k] <= psg_cnt_d[k];
      fm_cen_q  <= fm_cen_d;
      psg_cen_q <= psg_cen_d;
      state_q   <= state_d;
      pend_q    <= pend_d;
      ovr_q     <= ovr_d;
      sel_q     <= sel_d;
      tmo_q     <= tmo_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      to_q      <= to_d;
    end
  end

  assign fm_cen    = fm_cen_q;
  assign psg_cen   = psg_cen_q;
  assign mac_start = start_q;
  assign mac_sel   = sel_q;
  assign busy      = busy_q;
  assign overrun   = ovr_q;
  assign timeout   = to_q;

endmodule

// File: tb/tb_jt12_mix_sched.sv
// tb_jt12_mix_sched: directed bench for jt12_mix_sched with a cycle-level
// reference model, a grant scoreboard and a simple MAC responder.
module tb_jt12_mix_sched;

  localparam int unsigned FM_DIV  = 1008;
  localparam int unsigned PSG_DIV = 240;
  localparam int unsigned MAC_TMO = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mac_done = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] fm_cen;
  logic [2:0] psg_cen;
  logic       mac_start;
  logic [2:0] mac_sel;
  logic       busy;
  logic [6:0] overrun;
  logic       timeout;

  always #5 clk = ~clk;

  jt12_mix_sched #(
    .FM_DIV (FM_DIV),
    .PSG_DIV(PSG_DIV),
    .MAC_TMO(MAC_TMO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .fm_cen   (fm_cen),
    .psg_cen  (psg_cen),
    .mac_start(mac_start),
    .mac_sel  (mac_sel),
    .mac_done (mac_done),
    .busy     (busy),
    .overrun  (overrun),
    .timeout  (timeout),
    .clr      (clr)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;      // rising edges since reset release

  // reference model state (value after the latest edge)
  bit [6:0] m_cen, m_pend, m_ovr;
  bit       m_to, m_start, m_busy;
  int       m_phase;  // 0 idle, 1 start, 2 wait
  int       m_sel, m_age;
  bit       done_prev, clr_prev;

  // MAC responder: mac_lat cycles after a start it pulses done (0 = never)
  int mac_lat = 0;
  int due     = -1;

  bit gap_en = 1'b0;
  int last_start = -1;

  logic [2:0] sb[$];
  int fm0_hits[$], fm3_hits[$], psg2_hits[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [19:0] dut_vec();
    return {fm_cen, psg_cen, mac_start, mac_sel, busy, overrun, timeout};
  endfunction

  task automatic model_reset();
    m_cen = '0; m_pend = '0; m_ovr = '0;
    m_to = 1'b0; m_start = 1'b0; m_busy = 1'b0;
    m_phase = 0; m_sel = 0; m_age = 0;
    sb.delete();
    fm0_hits.delete(); fm3_hits.delete(); psg2_hits.delete();
    due = -1;
    last_start = -1;
  endtask

  // One rising edge of the scheduler as described by its behaviour
  task automatic model_edge();
    bit [6:0] ends;
    bit       abort;
    int       win;
    ends  = '0;
    abort = 1'b0;
    if (m_phase == 2) begin
      if (done_prev) ends[m_sel] = 1'b1;
      else if (m_age == int'(MAC_TMO) - 1) begin
        ends[m_sel] = 1'b1;
        abort = 1'b1;
      end
    end
    m_ovr   = (clr_prev ? 7'b0 : m_ovr) | (m_cen & m_pend & ~ends);
    m_to    = (clr_prev ? 1'b0 : m_to) | abort;
    m_start = (m_phase == 1);
    m_busy  = (m_phase == 1) || (m_phase == 2 && ends == '0);
    case (m_phase)
      0: if (m_pend != '0) begin
           win = 0;
           for (int i = 6; i >= 0; i--) if (m_pend[i]) win = i;
           m_sel = win;
           m_phase = 1;
         end
      1: begin m_phase = 2; m_age = 0; end
      default: begin
        m_age++;
        if (ends != '0) m_phase = 0;
      end
    endcase
    m_pend = (m_pend & ~ends) | m_cen;
    for (int k = 0; k < 4; k++) m_cen[k]     = (cyc % int'(FM_DIV >> k)) == 0;
    for (int k = 0; k < 3; k++) m_cen[4 + k] = (cyc % int'(PSG_DIV >> k)) == 0;
  endtask

  // Advance one clock, compare against the model, then drive the next inputs
  task automatic tick();
    logic [19:0] exp;
    done_prev = mac_done;
    clr_prev  = clr;
    @(negedge clk);
    cyc++;
    model_edge();
    exp = {m_cen[3:0], m_cen[6:4], m_start, 3'(m_sel), m_busy, m_ovr, m_to};
    chk("cycle", 32'(dut_vec()), 32'(exp));
    if (m_start) sb.push_back(3'(m_sel));
    if (fm_cen[0])  fm0_hits.push_back(cyc);
    if (fm_cen[3])  fm3_hits.push_back(cyc);
    if (psg_cen[2]) psg2_hits.push_back(cyc);
    if (mac_start) begin
      chk("sb_depth", 32'(sb.size()), 32'd1);
      if (sb.size() > 0) chk("grant", 32'(mac_sel), 32'(sb.pop_front()));
      if (gap_en && last_start >= 0)
        chk("start_gap_ge23", 32'(cyc - last_start >= 23), 32'd1);
      last_start = cyc;
      if (mac_lat > 0) due = cyc + mac_lat;
    end
    mac_done = (cyc == due);
  endtask

  task automatic run_until(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mac_done = 1'b0;
    clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'(dut_vec()), 32'd0);
    rst_n = 1'b1;
    model_reset();
    cyc = 0;
  endtask

  function automatic int gap_of(input int a, input int b, input int sz);
    return (sz >= 2) ? (b - a) : -1;
  endfunction

  initial begin
    if ((FM_DIV % 8) != 0 || (PSG_DIV % 4) != 0)
      $fatal(1, "divider configuration not divisible");

    // Strobe timing, first-grant latency, timeout, overrun, clr
    mac_lat = 0;
    do_reset();
    run_until(60);
    chk("psg2_first", 32'({fm_cen, psg_cen}), 32'h04);
    run_until(62);
    chk("no_start_yet", 32'(mac_start), 32'd0);
    run_until(63);
    chk("latency3", 32'({busy, mac_start, mac_sel}), 32'h1E);
    run_until(120);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_vs_set", 32'(overrun), 32'h40);
    run_until(126);
    chk("fm3_first", 32'(fm_cen), 32'h8);
    run_until(317);
    chk("pre_timeout", 32'({busy, timeout}), 32'h2);
    tick();
    chk("timeout_255", 32'({busy, timeout}), 32'h1);
    run_until(320);
    chk("grant_after_abort", 32'({mac_start, mac_sel}), 32'hA);
    run_until(400);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_flags", 32'({overrun, timeout}), 32'd0);
    run_until(2100);
    chk("fm0_first", 32'(fm0_hits.size() > 0 ? fm0_hits[0] : -1), 32'd1008);
    chk("fm0_period", 32'(gap_of(fm0_hits.size() > 1 ? fm0_hits[0] : 0,
                                 fm0_hits.size() > 1 ? fm0_hits[1] : 0, fm0_hits.size())), 32'd1008);
    chk("fm3_period", 32'(gap_of(fm3_hits.size() > 1 ? fm3_hits[0] : 0,
                                 fm3_hits.size() > 1 ? fm3_hits[1] : 0, fm3_hits.size())), 32'd126);
    chk("psg2_period", 32'(gap_of(psg2_hits.size() > 1 ? psg2_hits[0] : 0,
                                  psg2_hits.size() > 1 ? psg2_hits[1] : 0, psg2_hits.size())), 32'd60);

    // Done coincident with a new strobe of the same job
    mac_lat = 0;
    do_reset();
    run_until(121);
    chk("overrun_pending", 32'(overrun), 32'h40);
    run_until(150);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_overrun", 32'(overrun), 32'd0);
    run_until(180);
    chk("coinc_setup", 32'({psg_cen, busy, mac_sel}), 32'h4E);
    mac_done = 1'b1;
    mac_lat = 20;
    due = -1;
    tick();
    mac_done = 1'b0;
    chk("coinc_no_overrun", 32'({overrun, busy}), 32'd0);
    run_until(183);
    chk("grant_fm3", 32'({mac_start, mac_sel}), 32'hB);
    run_until(203);
    chk("busy_in_done_cycle", 32'({busy, mac_done}), 32'h3);
    tick();
    chk("busy_after_done", 32'(busy), 32'd0);
    run_until(206);
    chk("grant_psg1", 32'({mac_start, mac_sel}), 32'hD);
    run_until(229);
    chk("regrant_same_job", 32'({mac_start, mac_sel}), 32'hE);

    // Asynchronous reset in the middle of a job
    run_until(235);
    chk("busy_before_reset", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 32'(dut_vec()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mac_done = 1'b0;
    model_reset();
    cyc = 0;

    // Sustained run with a 20-cycle MAC over ten FM periods
    gap_en = 1'b1;
    run_until(60);
    chk("restart_psg2", 32'(psg_cen), 32'h4);
    run_until(126);
    chk("restart_fm3", 32'(fm_cen), 32'h8);
    run_until(10 * int'(FM_DIV) + 30);
    chk("no_timeout", 32'(timeout), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
